// File: rtl/sdu_dump_engine_if.sv
// Command, debug-memory and UART byte-stream signals of the dump engine.
// The master modport is the engine's view; the slave modport is the surrounding system's view.
interface sdu_dump_engine_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [1:0]       sel;
    logic [31:0]      base_addr;
    logic [CNT_W-1:0] count;
    logic [31:0]      addr;
    logic [31:0]      dout_dm;
    logic [31:0]      dout_im;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             busy;
    logic             done;

    modport master (
        input  start, sel, base_addr, count, dout_dm, dout_im, tx_ready,
        output addr, tx_data, tx_valid, busy, done
    );

    modport slave (
        output start, sel, base_addr, count, dout_dm, dout_im, tx_ready,
        input  addr, tx_data, tx_valid, busy, done
    );
endinterface

// File: rtl/sdu_dump_engine.sv
// Serial debug unit dump engine: prints CPU debug words or a memory range as
// ASCII hex lines (8 digits + CR + LF per word) on a valid/ready byte stream.
module sdu_dump_engine #(
    parameter int CNT_W     = 16,
    parameter bit HEX_UPPER = 1'b1
) (
    input  logic                clk,
    input  logic                rstn,
    sdu_dump_engine_if.master   bus,
    input  logic [31:0]         pc_chk,
    input  logic [31:0]         npc,
    input  logic [31:0]         pc,
    input  logic [31:0]         IR,
    input  logic [31:0]         CTL,
    input  logic [31:0]         A,
    input  logic [31:0]         B,
    input  logic [31:0]         Y,
    input  logic [31:0]         MDR,
    input  logic [31:0]         IMM
);
    typedef enum logic [2:0] {IDLE, LOAD, HEX, CR, LF, FIN} state_t;

    state_t           state, state_nxt;
    logic [1:0]       sel_q, sel_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      shreg_q, shreg_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [3:0]       word_idx_q, word_idx_d;
    logic [2:0]       nib_q, nib_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [31:0]      word_in;
    logic             handshake;
    logic             accept;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        return (HEX_UPPER ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
    endfunction

    assign handshake = tx_valid_q & bus.tx_ready;
    assign accept    = bus.start && (bus.sel != 2'd3);

    always_comb begin
        word_in = 32'h0;
        case (sel_q)
            2'd1:    word_in = bus.dout_dm;
            2'd2:    word_in = bus.dout_im;
            default: begin
                case (word_idx_q)
                    4'd0:    word_in = pc_chk;
                    4'd1:    word_in = npc;
                    4'd2:    word_in = pc;
                    4'd3:    word_in = IR;
                    4'd4:    word_in = CTL;
                    4'd5:    word_in = A;
                    4'd6:    word_in = B;
                    4'd7:    word_in = Y;
                    4'd8:    word_in = MDR;
                    4'd9:    word_in = IMM;
                    default: word_in = 32'h0;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            sel_q       <= 2'd0;
            addr_q      <= 32'h0;
            shreg_q     <= 32'h0;
            remaining_q <= '0;
            word_idx_q  <= 4'd0;
            nib_q       <= 3'd0;
            tx_data_q   <= 8'h0;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            shreg_q     <= shreg_d;
            remaining_q <= remaining_d;
            word_idx_q  <= word_idx_d;
            nib_q       <= nib_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)
                      state_nxt = (bus.sel != 2'd0 && bus.count == '0) ? FIN : LOAD;
            LOAD: state_nxt = HEX;
            HEX:  if (handshake && nib_q == 3'd7) state_nxt = CR;
            CR:   if (handshake) state_nxt = LF;
            LF:   if (handshake) state_nxt = (remaining_q == CNT_W'(1)) ? FIN : LOAD;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs: the next byte is prepared one cycle ahead so tx_data stays stable under stall.
    always_comb begin
        sel_d       = sel_q;
        addr_d      = addr_q;
        shreg_d     = shreg_q;
        remaining_d = remaining_q;
        word_idx_d  = word_idx_q;
        nib_d       = nib_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state)
            IDLE: if (accept) begin
                sel_d       = bus.sel;
                addr_d      = bus.base_addr;
                remaining_d = (bus.sel == 2'd0) ? CNT_W'(10) : bus.count;
                word_idx_d  = 4'd0;
                busy_d      = 1'b1;
            end
            LOAD: begin
                shreg_d    = word_in;
                nib_d      = 3'd0;
                tx_valid_d = 1'b1;
                tx_data_d  = hex_char(word_in[31:28]);
            end
            HEX: if (handshake) begin
                if (nib_q == 3'd7) begin
                    tx_data_d = 8'h0D;
                end else begin
                    nib_d     = nib_q + 3'd1;
                    shreg_d   = shreg_q << 4;
                    tx_data_d = hex_char(shreg_q[27:24]);
                end
            end
            CR: if (handshake) tx_data_d = 8'h0A;
            LF: if (handshake) begin
                remaining_d = remaining_q - CNT_W'(1);
                addr_d      = addr_q + 32'd1;
                word_idx_d  = word_idx_q + 4'd1;
                tx_valid_d  = 1'b0;
            end
            FIN: begin
                done_d     = 1'b1;
                busy_d     = 1'b0;
                tx_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.addr     = addr_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_sdu_dump_engine.sv
// Self-checking bench for sdu_dump_engine: table vectors, timing/reset sequences and
// random commands, all compared against a text-level model of the expected hex dump.
module tb_sdu_dump_engine;
    localparam int CNT_W = 16;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] base;
        int          cnt;
        int          ready_mode;
        bit          poke;
        bit          exp_done;
        int          exp_bytes;
        string       exp_line1;
        string       exp_line5;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] regs [10];
    logic [31:0] dm_seed = 32'h1357_9BDF;
    logic [31:0] im_seed = 32'h2468_ACE0;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          ready_mode = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          valid_cnt = 0;
    logic [7:0]  got_q [$];
    logic [7:0]  exp_q [$];
    logic [31:0] exp_addr;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h0;
    vec_t        vecs [7];

    always #5 clk = ~clk;

    sdu_dump_engine_if #(.CNT_W(CNT_W)) bus ();

    sdu_dump_engine #(.CNT_W(CNT_W), .HEX_UPPER(1'b1)) dut (
        .clk(clk), .rstn(rstn), .bus(bus),
        .pc_chk(regs[0]), .npc(regs[1]), .pc(regs[2]), .IR(regs[3]), .CTL(regs[4]),
        .A(regs[5]), .B(regs[6]), .Y(regs[7]), .MDR(regs[8]), .IMM(regs[9])
    );

    // Memory contents are a pure function of the address so the model can recompute them.
    function automatic logic [31:0] dm_val(input logic [31:0] a, input logic [31:0] seed);
        if (a == 32'd5) return 32'hDEAD_BEEF;
        if (a == 32'd6) return 32'h1234_5678;
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    function automatic logic [31:0] im_val(input logic [31:0] a, input logic [31:0] seed);
        return {a[15:0], a[31:16]} ^ seed;
    endfunction

    assign bus.dout_dm = dm_val(bus.addr, dm_seed);
    assign bus.dout_im = im_val(bus.addr, im_seed);

    always @(posedge clk) begin
        cyc++;
        #1;
        case (ready_mode)
            0:       bus.tx_ready = 1'b1;
            1:       bus.tx_ready = (cyc % 3 == 0);
            default: bus.tx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic checkText(input string name, input int offset, input string req);
        string s;
        s = "";
        for (int j = 0; j < req.len(); j++)
            if (offset + j < got_q.size()) s = {s, string'(got_q[offset + j])};
        n_cmp++;
        if (s != req) begin
            n_fail++;
            $display("[TB] FAIL %s: got \"%s\", required \"%s\"", name, s, req);
        end
    endtask

    task automatic checkStream(input string name);
        int bad;
        bad = -1;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
        if (bad < 0 && got_q.size() != exp_q.size()) bad = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        n_cmp++;
        if (bad >= 0) begin
            n_fail++;
            $display("[TB] FAIL %s stream: got %0d bytes, required %0d; first difference at byte %0d (got %0h, required %0h)",
                     name, got_q.size(), exp_q.size(), bad,
                     (bad < got_q.size()) ? got_q[bad] : 8'hxx, (bad < exp_q.size()) ? exp_q[bad] : 8'hxx);
        end
    endtask

    // Reference: each word printed with %08h, letters upper-cased, followed by CR LF.
    task automatic buildExpected(input logic [1:0] sel, input logic [31:0] base, input int cnt);
        int n;
        logic [31:0] a, w;
        string s;
        byte ch;
        exp_q.delete();
        n = (sel == 2'd3) ? 0 : (sel == 2'd0) ? 10 : cnt;
        for (int i = 0; i < n; i++) begin
            a = base + 32'(i);
            w = (sel == 2'd0) ? regs[i] : (sel == 2'd1) ? dm_val(a, dm_seed) : im_val(a, im_seed);
            s = $sformatf("%08h", w);
            for (int j = 0; j < 8; j++) begin
                ch = s[j];
                if (ch >= "a" && ch <= "f") ch = ch - 8'h20;
                exp_q.push_back(ch);
            end
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
        exp_addr = base + 32'(n);
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (prev_stall) begin
                checkOutput("stall_hold_valid", 32'(bus.tx_valid), 32'd1);
                checkOutput("stall_hold_data", 32'(bus.tx_data), 32'(prev_data));
            end
            if (bus.tx_valid) valid_cnt++;
            if (bus.tx_valid && bus.tx_ready) got_q.push_back(bus.tx_data);
            if (bus.done) begin
                done_cnt++;
                checkOutput("busy_low_with_done", 32'(bus.busy), 32'd0);
            end
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_data  = bus.tx_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic startCommand(input logic [1:0] sel, input logic [31:0] base, input int cnt);
        buildExpected(sel, base, cnt);
        got_q.delete();
        done_cnt  = 0;
        valid_cnt = 0;
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.sel       = sel;
        bus.base_addr = base;
        bus.count     = CNT_W'(cnt);
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.sel       = 2'($urandom_range(0, 3));
        bus.base_addr = $urandom;
        bus.count     = CNT_W'($urandom);
    endtask

    task automatic waitDone(input string name, input bit exp_done, input bit poke);
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #2;
            if (poke && c == 25) begin
                bus.start = 1'b1; bus.sel = 2'd2; bus.base_addr = 32'h0; bus.count = '0;
            end
            if (poke && c == 26) bus.start = 1'b0;
            if (exp_done && done_cnt > 0 && c > 30) break;
            if (!exp_done && c >= 30) break;
        end
        repeat (5) @(posedge clk);
        #2;
        checkOutput({name, " done_count"}, 32'(done_cnt), exp_done ? 32'd1 : 32'd0);
        checkOutput({name, " busy_idle"}, 32'(bus.busy), 32'd0);
        if (exp_done) checkOutput({name, " final_addr"}, bus.addr, exp_addr);
        checkStream(name);
    endtask

    task automatic applyStimulus(input vec_t v);
        ready_mode = v.ready_mode;
        startCommand(v.sel, v.base, v.cnt);
        waitDone(v.name, v.exp_done, v.poke);
        checkOutput({v.name, " byte_count"}, 32'(got_q.size()), 32'(v.exp_bytes));
        if (v.exp_line1 != "") checkText({v.name, " line1"}, 0, v.exp_line1);
        if (v.exp_line5 != "") checkText({v.name, " line5"}, 40, v.exp_line5);
    endtask

    task automatic timingRun(input logic [1:0] sel, input int cnt, input string name);
        ready_mode = 0;
        startCommand(sel, 32'h40, cnt);
        @(negedge clk);
        checkOutput({name, " c1_busy"}, 32'(bus.busy), 32'd1);
        checkOutput({name, " c1_valid"}, 32'(bus.tx_valid), 32'd0);
        @(negedge clk);
        checkOutput({name, " c2_valid"}, 32'(bus.tx_valid), (sel == 2'd0) ? 32'd1 : 32'd0);
        checkOutput({name, " c2_done"}, 32'(bus.done), (sel == 2'd0) ? 32'd0 : 32'd1);
        checkOutput({name, " c2_busy"}, 32'(bus.busy), (sel == 2'd0) ? 32'd1 : 32'd0);
        waitDone(name, 1'b1, 1'b0);
        if (sel != 2'd0) checkOutput({name, " no_valid"}, 32'(valid_cnt), 32'd0);
    endtask

    task automatic setRegs();
        for (int i = 0; i < 10; i++) regs[i] = $urandom;
        regs[0] = 32'h0000_000A;
        regs[1] = 32'h0;
        regs[3] = 32'h0000_0002;
        regs[4] = 32'h0000_0008;
    endtask

    initial begin
        bus.start = 1'b0; bus.sel = 2'd0; bus.base_addr = 32'h0; bus.count = '0; bus.tx_ready = 1'b1;
        setRegs();
        vecs[0] = '{2'd0, 32'h100, 7, 0, 1'b0, 1'b1, 100, "0000000A", "00000008", "regdump"};
        vecs[1] = '{2'd1, 32'd5, 2, 0, 1'b0, 1'b1, 20, "DEADBEEF\r\n12345678\r\n", "", "dmdump"};
        vecs[2] = '{2'd0, 32'h0, 0, 1, 1'b1, 1'b1, 100, "0000000A", "00000008", "backpressure"};
        vecs[3] = '{2'd1, 32'd5, 2, 1, 1'b1, 1'b1, 20, "DEADBEEF", "", "dm_backpressure"};
        vecs[4] = '{2'd2, 32'h40, 0, 0, 1'b0, 1'b1, 0, "", "", "zerocount"};
        vecs[5] = '{2'd2, 32'hFFFF_FFFF, 2, 2, 1'b0, 1'b1, 20, "", "", "addr_wrap"};
        vecs[6] = '{2'd3, 32'h0, 4, 0, 1'b0, 1'b0, 0, "", "", "reserved_sel"};

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset tx_valid", 32'(bus.tx_valid), 32'd0);
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        checkOutput("reset addr", bus.addr, 32'h0);
        checkOutput("reset tx_data", 32'(bus.tx_data), 32'h0);
        @(posedge clk); #1;
        rstn = 1'b1;

        foreach (vecs[i]) applyStimulus(vecs[i]);

        timingRun(2'd0, 0, "timing_regdump");
        timingRun(2'd2, 0, "timing_zerocount");

        // Reset while the fourth hex digit is on the bus.
        ready_mode = 0;
        startCommand(2'd0, 32'h0, 0);
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #2;
            if (got_q.size() >= 3) break;
        end
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("midreset tx_valid", 32'(bus.tx_valid), 32'd0);
        checkOutput("midreset busy", 32'(bus.busy), 32'd0);
        checkOutput("midreset addr", bus.addr, 32'h0);
        checkOutput("midreset bytes_before", 32'(got_q.size()), 32'd3);
        applyStimulus(vecs[0]);

        for (int r = 0; r < 12; r++) begin
            vec_t v;
            for (int i = 0; i < 10; i++) regs[i] = $urandom;
            dm_seed = $urandom;
            im_seed = $urandom;
            v.sel        = 2'($urandom_range(0, 2));
            v.base       = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
            v.cnt        = $urandom_range(0, 4);
            v.ready_mode = $urandom_range(0, 2);
            v.poke       = 1'b0;
            v.exp_done   = 1'b1;
            v.exp_bytes  = (v.sel == 2'd0) ? 100 : 10 * v.cnt;
            v.exp_line1  = "";
            v.exp_line5  = "";
            v.name       = $sformatf("random%0d", r);
            applyStimulus(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
